// File: rtl/id_stage_if.sv
// -----------------------------------------------------------------------------
// id_stage_if
// Purpose : Bundles the decode-stage traffic of a MIPS-like pipeline: the
//           IF/ID inputs, the write-back port into the register file, and the
//           decoded controls and operands leaving the stage.
// Ports   : none (interface). Modports:
//           master - IF/WB side: drives pc_in, instruction_in, writeData_WB,
//                    writeAddr_WB, regWrite_WB; observes every decode output.
//           slave  - the decode stage: the reverse directions.
// -----------------------------------------------------------------------------
interface id_stage_if;
   logic [31:0] pc_in;
   logic [31:0] instruction_in;
   logic [31:0] writeData_WB;
   logic [4:0]  writeAddr_WB;
   logic        regWrite_WB;

   logic [31:0] pc_out;
   logic [31:0] instruction_out;
   logic        regDst, regWrite, aluSrc, branch, jump, memRead, memWrite;
   logic        memToReg, atomic, beq, jal, jr, lui, zeroExt, useSign;
   logic [3:0]  mMask;
   logic [3:0]  aluOp;
   logic [31:0] rsData;
   logic [31:0] rtData;

   modport master (
      output pc_in, instruction_in, writeData_WB, writeAddr_WB, regWrite_WB,
      input  pc_out, instruction_out, regDst, regWrite, aluSrc, branch, jump,
             memRead, memWrite, memToReg, atomic, beq, jal, jr, lui, zeroExt,
             useSign, mMask, aluOp, rsData, rtData
   );

   modport slave (
      input  pc_in, instruction_in, writeData_WB, writeAddr_WB, regWrite_WB,
      output pc_out, instruction_out, regDst, regWrite, aluSrc, branch, jump,
             memRead, memWrite, memToReg, atomic, beq, jal, jr, lui, zeroExt,
             useSign, mMask, aluOp, rsData, rtData
   );
endinterface

// File: rtl/id_stage.sv
// -----------------------------------------------------------------------------
// id_stage
// Purpose : Instruction-decode stage. Holds the IF/ID pipeline register,
//           decodes the registered instruction into datapath controls, and
//           owns the 32x32 register file with write-back bypass on reads.
// Ports   : clk   - rising-edge clock
//           rst   - asynchronous active-low reset
//           io_id - id_stage_if.slave: IF inputs, WB write port, decode outputs
// -----------------------------------------------------------------------------
module id_stage (
   input logic       clk,
   input logic       rst,
   id_stage_if.slave io_id
);

   typedef enum logic [3:0] {
      ALU_ADD = 4'd0, ALU_SUB = 4'd1, ALU_AND = 4'd2, ALU_OR  = 4'd3,
      ALU_XOR = 4'd4, ALU_NOR = 4'd5, ALU_SLT = 4'd6, ALU_SLL = 4'd7,
      ALU_SRL = 4'd8, ALU_SRA = 4'd9
   } alu_op_e;

   typedef struct packed {
      logic    reg_dst;
      logic    reg_write;
      logic    alu_src;
      logic    branch;
      logic    jump;
      logic    mem_read;
      logic    mem_write;
      logic    mem_to_reg;
      logic    atomic;
      logic    beq;
      logic    jal;
      logic    jr;
      logic    lui;
      logic    zero_ext;
      logic    use_sign;
      logic [3:0] m_mask;
      alu_op_e alu_op;
   } ctrl_t;

   logic [31:0] r_pc;
   logic [31:0] r_instr;
   logic [31:0] r_regs [0:31];

   logic [5:0]  w_op;
   logic [5:0]  w_funct;
   logic [4:0]  w_rs;
   logic [4:0]  w_rt;
   logic        w_wr_en;
   logic [31:0] w_rs_data;
   logic [31:0] w_rt_data;
   ctrl_t       w_ctrl;

   // IF/ID pipeline register: no stall or flush, loads every cycle.
   // NOTE: state updates use non-blocking assignments so every flop samples
   // pre-edge values regardless of block ordering.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_pc    <= '0;
         r_instr <= '0;
      end else begin
         r_pc    <= io_id.pc_in;
         r_instr <= io_id.instruction_in;
      end
   end

   // R0 is hardwired: writes to it are dropped here and reads force zero.
   assign w_wr_en = io_id.regWrite_WB && (io_id.writeAddr_WB != 5'd0);

   // NOTE: the register file is cleared by reset, so it is built from
   // resettable flops rather than a RAM macro without a reset port.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         for (int i = 0; i < 32; i++) r_regs[i] <= '0;
      end else if (w_wr_en) begin
         r_regs[io_id.writeAddr_WB] <= io_id.writeData_WB;
      end
   end

   assign w_op    = r_instr[31:26];
   assign w_rs    = r_instr[25:21];
   assign w_rt    = r_instr[20:16];
   assign w_funct = r_instr[5:0];

   // Write-through bypass lets an instruction in decode see the value being
   // written back in the same cycle.
   assign w_rs_data = (w_rs == 5'd0) ? 32'd0 :
                      (w_wr_en && io_id.writeAddr_WB == w_rs) ? io_id.writeData_WB :
                      r_regs[w_rs];
   assign w_rt_data = (w_rt == 5'd0) ? 32'd0 :
                      (w_wr_en && io_id.writeAddr_WB == w_rt) ? io_id.writeData_WB :
                      r_regs[w_rt];

   // NOTE: every field gets a default before the case so no path leaves a
   // control unassigned and infers a latch.
   always_comb begin
      w_ctrl = '0;
      // An all-zero word would otherwise decode as sll; it is the canonical
      // NOP and, after reset, must leave every control low.
      if (r_instr != 32'd0) begin
         case (w_op)
            6'h00: begin
               w_ctrl.reg_dst   = 1'b1;
               w_ctrl.reg_write = 1'b1;
               case (w_funct)
                  6'h20: begin w_ctrl.alu_op = ALU_ADD; w_ctrl.use_sign = 1'b1; end
                  6'h21: w_ctrl.alu_op = ALU_ADD;
                  6'h22: begin w_ctrl.alu_op = ALU_SUB; w_ctrl.use_sign = 1'b1; end
                  6'h23: w_ctrl.alu_op = ALU_SUB;
                  6'h24: w_ctrl.alu_op = ALU_AND;
                  6'h25: w_ctrl.alu_op = ALU_OR;
                  6'h26: w_ctrl.alu_op = ALU_XOR;
                  6'h27: w_ctrl.alu_op = ALU_NOR;
                  6'h2A: begin w_ctrl.alu_op = ALU_SLT; w_ctrl.use_sign = 1'b1; end
                  6'h2B: w_ctrl.alu_op = ALU_SLT;
                  6'h00: w_ctrl.alu_op = ALU_SLL;
                  6'h02: w_ctrl.alu_op = ALU_SRL;
                  6'h03: w_ctrl.alu_op = ALU_SRA;
                  6'h08: begin w_ctrl.jr = 1'b1; w_ctrl.reg_write = 1'b0; end
                  default: w_ctrl = '0;
               endcase
            end
            6'h08, 6'h09, 6'h0A, 6'h0B, 6'h0C, 6'h0D, 6'h0E, 6'h0F: begin
               w_ctrl.alu_src   = 1'b1;
               w_ctrl.reg_write = 1'b1;
               case (w_op)
                  6'h08: w_ctrl.use_sign = 1'b1;
                  6'h0A: begin w_ctrl.alu_op = ALU_SLT; w_ctrl.use_sign = 1'b1; end
                  6'h0B: w_ctrl.alu_op = ALU_SLT;
                  6'h0C: begin w_ctrl.alu_op = ALU_AND; w_ctrl.zero_ext = 1'b1; end
                  6'h0D: begin w_ctrl.alu_op = ALU_OR;  w_ctrl.zero_ext = 1'b1; end
                  6'h0E: begin w_ctrl.alu_op = ALU_XOR; w_ctrl.zero_ext = 1'b1; end
                  6'h0F: w_ctrl.lui = 1'b1;
                  default: ;
               endcase
            end
            6'h20, 6'h21, 6'h23, 6'h24, 6'h25, 6'h30: begin
               w_ctrl.mem_read   = 1'b1;
               w_ctrl.mem_to_reg = 1'b1;
               w_ctrl.reg_write  = 1'b1;
               w_ctrl.alu_src    = 1'b1;
               case (w_op)
                  6'h20: begin w_ctrl.m_mask = 4'b0001; w_ctrl.use_sign = 1'b1; end
                  6'h24: w_ctrl.m_mask = 4'b0001;
                  6'h21: begin w_ctrl.m_mask = 4'b0011; w_ctrl.use_sign = 1'b1; end
                  6'h25: w_ctrl.m_mask = 4'b0011;
                  6'h30: begin w_ctrl.m_mask = 4'b1111; w_ctrl.atomic = 1'b1; end
                  default: w_ctrl.m_mask = 4'b1111;
               endcase
            end
            6'h28, 6'h29, 6'h2B, 6'h38: begin
               w_ctrl.mem_write = 1'b1;
               w_ctrl.alu_src   = 1'b1;
               case (w_op)
                  6'h28: w_ctrl.m_mask = 4'b0001;
                  6'h29: w_ctrl.m_mask = 4'b0011;
                  6'h38: begin
                     // sc also writes its success flag back to rt.
                     w_ctrl.m_mask    = 4'b1111;
                     w_ctrl.atomic    = 1'b1;
                     w_ctrl.reg_write = 1'b1;
                  end
                  default: w_ctrl.m_mask = 4'b1111;
               endcase
            end
            6'h04: begin
               w_ctrl.branch = 1'b1;
               w_ctrl.beq    = 1'b1;
               w_ctrl.alu_op = ALU_SUB;
            end
            6'h05: begin
               w_ctrl.branch = 1'b1;
               w_ctrl.alu_op = ALU_SUB;
            end
            6'h02: w_ctrl.jump = 1'b1;
            6'h03: begin
               w_ctrl.jump      = 1'b1;
               w_ctrl.jal       = 1'b1;
               w_ctrl.reg_write = 1'b1;
            end
            default: w_ctrl = '0;
         endcase
      end
   end

   assign io_id.pc_out          = r_pc;
   assign io_id.instruction_out = r_instr;
   assign io_id.rsData          = w_rs_data;
   assign io_id.rtData          = w_rt_data;
   assign io_id.regDst          = w_ctrl.reg_dst;
   assign io_id.regWrite        = w_ctrl.reg_write;
   assign io_id.aluSrc          = w_ctrl.alu_src;
   assign io_id.branch          = w_ctrl.branch;
   assign io_id.jump            = w_ctrl.jump;
   assign io_id.memRead         = w_ctrl.mem_read;
   assign io_id.memWrite        = w_ctrl.mem_write;
   assign io_id.memToReg        = w_ctrl.mem_to_reg;
   assign io_id.atomic          = w_ctrl.atomic;
   assign io_id.beq             = w_ctrl.beq;
   assign io_id.jal             = w_ctrl.jal;
   assign io_id.jr              = w_ctrl.jr;
   assign io_id.lui             = w_ctrl.lui;
   assign io_id.zeroExt         = w_ctrl.zero_ext;
   assign io_id.useSign         = w_ctrl.use_sign;
   assign io_id.mMask           = w_ctrl.m_mask;
   assign io_id.aluOp           = w_ctrl.alu_op;

endmodule

// File: tb/tb_id_stage.sv
// -----------------------------------------------------------------------------
// tb_id_stage
// Purpose : Self-checking bench for id_stage. Directed scenarios for reset,
//           decode examples, bypass and R0, followed by randomized traffic
//           compared against a table-driven reference model.
// Ports   : none (top-level bench).
// -----------------------------------------------------------------------------
module tb_id_stage;

   logic clk;
   logic rst;
   int   checks = 0;
   int   errors = 0;

   id_stage_if bus ();

   id_stage dut (
      .clk   (clk),
      .rst   (rst),
      .io_id (bus.slave)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Control vector layout: 15 flags, then mMask[7:4], then aluOp[3:0].
   localparam logic [22:0] F_RD = 23'h400000, F_RW = 23'h200000, F_AS = 23'h100000;
   localparam logic [22:0] F_BR = 23'h080000, F_JP = 23'h040000, F_MR = 23'h020000;
   localparam logic [22:0] F_MW = 23'h010000, F_MT = 23'h008000, F_AT = 23'h004000;
   localparam logic [22:0] F_BQ = 23'h002000, F_JL = 23'h001000, F_JR = 23'h000800;
   localparam logic [22:0] F_LU = 23'h000400, F_ZE = 23'h000200, F_US = 23'h000100;
   localparam logic [22:0] M4 = 23'h0000F0, M2 = 23'h000030, M1 = 23'h000010;

   typedef struct {
      logic [5:0]  op;
      int          funct;   // -1 when the opcode alone identifies the instruction
      logic [22:0] ctl;
   } entry_t;

   entry_t      tbl[$];
   logic [31:0] m_regs [32];
   logic [31:0] m_pc;
   logic [31:0] m_ins;

   function automatic void add(logic [5:0] op, int funct, logic [22:0] ctl);
      entry_t e;
      e.op = op; e.funct = funct; e.ctl = ctl;
      tbl.push_back(e);
   endfunction

   function automatic void build_table();
      logic [22:0] r, i, l, s;
      r = F_RD | F_RW;
      i = F_AS | F_RW;
      l = F_MR | F_MT | F_RW | F_AS;
      s = F_MW | F_AS;
      add(6'h00, 'h20, r | F_US | 23'd0);  add(6'h00, 'h21, r | 23'd0);
      add(6'h00, 'h22, r | F_US | 23'd1);  add(6'h00, 'h23, r | 23'd1);
      add(6'h00, 'h24, r | 23'd2);         add(6'h00, 'h25, r | 23'd3);
      add(6'h00, 'h26, r | 23'd4);         add(6'h00, 'h27, r | 23'd5);
      add(6'h00, 'h2A, r | F_US | 23'd6);  add(6'h00, 'h2B, r | 23'd6);
      add(6'h00, 'h00, r | 23'd7);         add(6'h00, 'h02, r | 23'd8);
      add(6'h00, 'h03, r | 23'd9);         add(6'h00, 'h08, F_RD | F_JR);
      add(6'h08, -1, i | F_US);            add(6'h09, -1, i);
      add(6'h0A, -1, i | F_US | 23'd6);    add(6'h0B, -1, i | 23'd6);
      add(6'h0C, -1, i | F_ZE | 23'd2);    add(6'h0D, -1, i | F_ZE | 23'd3);
      add(6'h0E, -1, i | F_ZE | 23'd4);    add(6'h0F, -1, i | F_LU);
      add(6'h23, -1, l | M4);              add(6'h21, -1, l | M2 | F_US);
      add(6'h25, -1, l | M2);              add(6'h20, -1, l | M1 | F_US);
      add(6'h24, -1, l | M1);              add(6'h30, -1, l | M4 | F_AT);
      add(6'h2B, -1, s | M4);              add(6'h29, -1, s | M2);
      add(6'h28, -1, s | M1);              add(6'h38, -1, s | M4 | F_AT | F_RW);
      add(6'h04, -1, F_BR | F_BQ | 23'd1); add(6'h05, -1, F_BR | 23'd1);
      add(6'h02, -1, F_JP);                add(6'h03, -1, F_JP | F_JL | F_RW);
   endfunction

   function automatic logic [22:0] exp_ctl(logic [31:0] ins);
      if (ins == 32'd0) return '0;
      foreach (tbl[k])
         if (tbl[k].op == ins[31:26] && (tbl[k].funct < 0 || tbl[k].funct == int'(ins[5:0])))
            return tbl[k].ctl;
      return '0;
   endfunction

   function automatic logic [31:0] exp_read(logic [4:0] a);
      if (a == 5'd0) return 32'd0;
      if (rst && bus.regWrite_WB && bus.writeAddr_WB == a) return bus.writeData_WB;
      return m_regs[a];
   endfunction

   function automatic logic [22:0] obs_ctl();
      return {bus.regDst, bus.regWrite, bus.aluSrc, bus.branch, bus.jump,
              bus.memRead, bus.memWrite, bus.memToReg, bus.atomic, bus.beq,
              bus.jal, bus.jr, bus.lui, bus.zeroExt, bus.useSign,
              bus.mMask, bus.aluOp};
   endfunction

   task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic drive(logic [31:0] pc, logic [31:0] ins, logic wb_en,
                        logic [4:0] wb_addr, logic [31:0] wb_data);
      bus.pc_in          = pc;
      bus.instruction_in = ins;
      bus.regWrite_WB    = wb_en;
      bus.writeAddr_WB   = wb_addr;
      bus.writeData_WB   = wb_data;
   endtask

   task automatic model_reset();
      m_pc  = '0;
      m_ins = '0;
      foreach (m_regs[k]) m_regs[k] = '0;
   endtask

   // One clock: update the model with the values present at the edge.
   task automatic clk_step();
      @(posedge clk);
      if (!rst) begin
         model_reset();
      end else begin
         if (bus.regWrite_WB && bus.writeAddr_WB != 5'd0)
            m_regs[bus.writeAddr_WB] = bus.writeData_WB;
         m_pc  = bus.pc_in;
         m_ins = bus.instruction_in;
      end
      @(negedge clk);
   endtask

   task automatic check_all(string tag);
      #1;
      chk({tag, "_pc"},   bus.pc_out, m_pc);
      chk({tag, "_ins"},  bus.instruction_out, m_ins);
      chk({tag, "_ctl"},  32'(obs_ctl()), 32'(exp_ctl(m_ins)));
      chk({tag, "_rs"},   bus.rsData, exp_read(m_ins[25:21]));
      chk({tag, "_rt"},   bus.rtData, exp_read(m_ins[20:16]));
   endtask

   initial begin
      logic [31:0] ins;
      logic [4:0]  wa;
      entry_t      e;
      int          mode;

      build_table();
      model_reset();

      // Reset holds everything at zero and ignores the WB port.
      rst = 1'b0;
      drive(32'h1000_0000, 32'hFFFF_FFFF, 1'b1, 5'd7, 32'hDEAD_BEEF);
      clk_step();
      clk_step();
      #1;
      chk("rst_pc", bus.pc_out, 32'd0);
      chk("rst_ins", bus.instruction_out, 32'd0);
      chk("rst_ctl", 32'(obs_ctl()), 32'd0);

      rst = 1'b1;
      drive(32'd0, 32'h0007_0000, 1'b0, 5'd0, 32'd0);  // rt = 7
      clk_step();
      check_all("rst_r7");

      // add $3,$1,$2 after loading R1/R2.
      drive(32'd0, 32'd0, 1'b1, 5'd1, 32'hAAAA_AAAA);
      clk_step();
      drive(32'd0, 32'd0, 1'b1, 5'd2, 32'h5555_5555);
      clk_step();
      drive(32'h0040_0000, 32'h0022_1820, 1'b0, 5'd0, 32'd0);
      clk_step();
      check_all("add");
      chk("add_pc_const", bus.pc_out, 32'h0040_0000);
      chk("add_ctl_const", 32'(obs_ctl()), 32'(F_RD | F_RW | F_US));
      chk("add_rs_const", bus.rsData, 32'hAAAA_AAAA);
      chk("add_rt_const", bus.rtData, 32'h5555_5555);

      drive(32'h0040_0004, 32'h3022_000F, 1'b0, 5'd0, 32'd0);
      clk_step();
      check_all("andi");
      chk("andi_ctl_const", 32'(obs_ctl()), 32'(F_AS | F_RW | F_ZE | 23'd2));

      // Reset pulse mid-sequence clears pipeline and registers.
      #2 rst = 1'b0;
      model_reset();
      #1;
      chk("mid_rst_pc", bus.pc_out, 32'd0);
      chk("mid_rst_ins", bus.instruction_out, 32'd0);
      clk_step();
      rst = 1'b1;
      drive(32'h0040_0008, 32'h1022_0004, 1'b0, 5'd0, 32'd0);
      clk_step();
      check_all("beq");
      chk("beq_ctl_const", 32'(obs_ctl()), 32'(F_BR | F_BQ | 23'd1));
      chk("beq_rs_const", bus.rsData, 32'd0);

      // Same-cycle bypass to rs, then R0 stays zero.
      drive(32'h0040_000C, 32'h20A5_0000, 1'b0, 5'd0, 32'd0);
      clk_step();
      drive(32'h0040_0010, 32'd0, 1'b1, 5'd5, 32'h1234_5678);
      check_all("bypass");
      chk("bypass_const", bus.rsData, 32'h1234_5678);
      clk_step();
      drive(32'h0040_0014, 32'h2000_0000, 1'b1, 5'd0, 32'hFFFF_FFFF);
      clk_step();
      check_all("r0");
      chk("r0_const", bus.rsData, 32'd0);

      // lb, lhu, sc, jal, jr.
      drive(32'd0, 32'h80A6_0000, 1'b0, 5'd0, 32'd0); clk_step(); check_all("lb");
      drive(32'd0, 32'h94A6_0000, 1'b0, 5'd0, 32'd0); clk_step(); check_all("lhu");
      drive(32'd0, 32'hE0A6_0000, 1'b0, 5'd0, 32'd0); clk_step(); check_all("sc");
      drive(32'd0, 32'h0C00_0010, 1'b0, 5'd0, 32'd0); clk_step(); check_all("jal");
      drive(32'd0, 32'h00A0_0008, 1'b0, 5'd0, 32'd0); clk_step(); check_all("jr");
      chk("jr_ctl_const", 32'(obs_ctl()), 32'(F_RD | F_JR));

      // Randomized traffic.
      for (int n = 0; n < 400; n++) begin
         mode = $urandom_range(0, 4);
         ins  = $urandom;
         if (mode <= 1) begin
            e = tbl[$urandom_range(0, tbl.size() - 1)];
            ins[31:26] = e.op;
            if (e.funct >= 0) ins[5:0] = 6'(e.funct);
         end else if (mode == 2) begin
            ins[31:26] = 6'h00;
         end else if (mode == 3 && ($urandom_range(0, 3) == 0)) begin
            ins = 32'd0;
         end
         wa = ($urandom_range(0, 1) == 1) ? m_ins[25:21] : 5'($urandom);
         drive($urandom, ins, 1'($urandom), wa, $urandom);
         check_all("rnd_pre");
         clk_step();
      end
      check_all("rnd_end");

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
